note_period_gen: RTL

Note-to-period front end for the synthesizer's PWM tone stage. Accepts note requests (MIDI note number, duration in ms, volume) over a valid/ready handshake. Converts each note to a clock-cycle period and drives the PWM stage's period-load pulse, period and volume for the requested duration. Sits between the exercise/sequence controller and the PWM tone generator.

---
 rtl/note_period_gen_pkg.sv | 48 ++++
 rtl/note_period_gen_if.sv | 33 +++
 rtl/note_period_gen_lut.sv | 54 +++++
 rtl/note_period_gen.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/note_period_gen_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | note_period_gen_pkg                                                        |
// | Shared widths, FSM encoding and MIDI octave -1 reference frequencies.      |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
package note_period_gen_pkg;

    localparam int NOTE_W   = 7;
    localparam int DUR_W    = 16;
    localparam int PERIOD_W = 32;
    localparam int VOL_W    = 4;

    typedef logic [1:0] state_t;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] PLAY = 2'd2;

    // Octave -1 frequencies, C-1 .. B-1, in micro-hertz.
    function automatic logic [31:0] ref_uhz(input int idx);
        case (idx)
            0:       return 32'd8175799;
            1:       return 32'd8661957;
            2:       return 32'd9177024;
            3:       return 32'd9722718;
            4:       return 32'd10300861;
            5:       return 32'd10913383;
            6:       return 32'd11562326;
            7:       return 32'd12249857;
            8:       return 32'd12978272;
            9:       return 32'd13750000;
            10:      return 32'd14567618;
            default: return 32'd15433853;
        endcase
    endfunction

    // round(clk_hz / f(idx)) using integer micro-hertz arithmetic
    function automatic logic [PERIOD_W-1:0] base_period(input int clk_hz, input int idx);
        logic [63:0] num;
        logic [63:0] den;
        den = 64'(ref_uhz(idx));
        num = 64'(clk_hz) * 64'd1000000 + (den >> 1);
        return PERIOD_W'(num / den);
    endfunction

endpackage
`default_nettype wire

// File: rtl/note_period_gen_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | note_period_gen_if                                                         |
// | Note request handshake plus period/volume outputs to the PWM stage.        |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
interface note_period_gen_if
    import note_period_gen_pkg::*;
;
    logic                note_valid;
    logic                note_ready;
    logic [NOTE_W-1:0]   note_num;
    logic [DUR_W-1:0]    note_dur;
    logic [VOL_W-1:0]    note_vol;
    logic                stop;
    logic                new_period;
    logic [PERIOD_W-1:0] clks_per_period;
    logic [VOL_W-1:0]    volume;
    logic                busy;
    logic                done;

    modport master (
        output note_valid, note_num, note_dur, note_vol, stop,
        input  note_ready, new_period, clks_per_period, volume, busy, done
    );

    modport slave (
        input  note_valid, note_num, note_dur, note_vol, stop,
        output note_ready, new_period, clks_per_period, volume, busy, done
    );

endinterface
`default_nettype wire

// File: rtl/note_period_gen_lut.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | note_period_lut                                                            |
// | MIDI note number to clock-cycle period, one cycle of latency.              |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module note_period_lut
    import note_period_gen_pkg::*;
#(
    parameter int CLK_HZ = 100_000_000
) (
    input  wire logic                clk,
    input  wire logic                resetn,
    input  wire logic [NOTE_W-1:0]   i_note,
    output logic      [PERIOD_W-1:0] o_period
);

    logic [PERIOD_W-1:0] w_rom [12];
    logic [3:0]          w_oct;
    logic [NOTE_W-1:0]   w_oct_base;
    logic [3:0]          w_semi;
    logic [PERIOD_W-1:0] r_period;

    for (genvar gi = 0; gi < 12; gi++) begin : g_rom
        localparam logic [PERIOD_W-1:0] c_base = base_period(CLK_HZ, gi);
        assign w_rom[gi] = c_base;
    end

    // Highest octave boundary not above the note wins; avoids a divider.
    always_comb begin
        w_oct      = 4'd0;
        w_oct_base = '0;
        for (int k = 1; k <= 10; k++) begin
            if (i_note >= NOTE_W'(12 * k)) begin
                w_oct      = 4'(k);
                w_oct_base = NOTE_W'(12 * k);
            end
        end
    end

    assign w_semi = 4'(i_note - w_oct_base);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_period <= '0;
        end else begin
            r_period <= w_rom[w_semi] >> w_oct;
        end
    end

    assign o_period = r_period;

endmodule
`default_nettype wire

// File: rtl/note_period_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | note_period_gen                                                            |
// | Note request -> PWM period/volume for the requested duration.              |
// | Optional macro NOTE_GAP_EN: mute the final GAP_MS ticks of each note.      |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module note_period_gen
    import note_period_gen_pkg::*;
#(
    parameter int CLK_HZ  = 100_000_000,
    parameter int TICK_HZ = 1000,
    parameter int GAP_MS  = 10
) (
    input  wire logic         clk,
    input  wire logic         resetn,
    note_period_gen_if.slave  bus
);

    localparam int c_tick_cyc = CLK_HZ / TICK_HZ;
    localparam int c_pre_w    = (c_tick_cyc > 1) ? $clog2(c_tick_cyc) : 1;
    localparam logic [c_pre_w-1:0] c_pre_max   = c_pre_w'(c_tick_cyc - 1);
    localparam logic [DUR_W-1:0]   c_gap_ticks = DUR_W'(GAP_MS);
`ifdef NOTE_GAP_EN
    localparam logic c_gap_en = 1'b1;
`else
    localparam logic c_gap_en = 1'b0;
`endif

    state_t              r_state;
    logic [NOTE_W-1:0]   r_note;
    logic [DUR_W-1:0]    r_dur;
    logic [VOL_W-1:0]    r_vol;
    logic [c_pre_w-1:0]  r_pre;
    logic [DUR_W-1:0]    r_dur_cnt;
    logic                r_ready_en;
    logic                r_new_period;
    logic [PERIOD_W-1:0] r_period;
    logic [VOL_W-1:0]    r_volume;
    logic                r_done;

    logic [PERIOD_W-1:0] w_lut_period;
    logic                w_ready;
    logic                w_wrap;
    logic [DUR_W-1:0]    w_dur_dec;
    logic                w_mute_entry;
    logic                w_mute_wrap;

    // The LUT samples the bus note at the handshake edge, so its output is
    // valid throughout LOAD.
    note_period_lut #(
        .CLK_HZ (CLK_HZ)
    ) u_lut (
        .clk      (clk),
        .resetn   (resetn),
        .i_note   (bus.note_num),
        .o_period (w_lut_period)
    );

    assign w_ready      = r_ready_en & ~bus.stop;
    assign w_wrap       = (r_pre == c_pre_max);
    assign w_dur_dec    = r_dur_cnt - 1'b1;
    assign w_mute_entry = c_gap_en && (r_dur <= c_gap_ticks);
    assign w_mute_wrap  = c_gap_en && (w_dur_dec <= c_gap_ticks);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state      <= IDLE;
            r_note       <= '0;
            r_dur        <= '0;
            r_vol        <= '0;
            r_pre        <= '0;
            r_dur_cnt    <= '0;
            r_ready_en   <= 1'b0;
            r_new_period <= 1'b0;
            r_period     <= '0;
            r_volume     <= '0;
            r_done       <= 1'b0;
        end else begin
            r_new_period <= 1'b0;
            r_done       <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_ready_en <= 1'b1;
                    if (bus.note_valid && w_ready) begin
                        r_note     <= bus.note_num;
                        r_dur      <= bus.note_dur;
                        r_vol      <= bus.note_vol;
                        r_ready_en <= 1'b0;
                        r_state    <= LOAD;
                    end
                end
                LOAD: begin
                    if (bus.stop) begin
                        r_volume   <= '0;
                        r_ready_en <= 1'b1;
                        r_state    <= IDLE;
                    end else if (r_dur == '0) begin
                        r_done     <= 1'b1;
                        r_ready_en <= 1'b1;
                        r_state    <= IDLE;
                    end else begin
                        r_pre     <= '0;
                        r_dur_cnt <= r_dur;
                        r_state   <= PLAY;
                        if (r_note != '0) begin
                            r_new_period <= 1'b1;
                            r_period     <= w_lut_period;
                            r_volume     <= w_mute_entry ? '0 : r_vol;
                        end else begin
                            r_volume <= '0;
                        end
                    end
                end
                PLAY: begin
                    if (bus.stop) begin
                        r_volume   <= '0;
                        r_ready_en <= 1'b1;
                        r_state    <= IDLE;
                    end else if (w_wrap) begin
                        r_pre     <= '0;
                        r_dur_cnt <= w_dur_dec;
                        if (w_dur_dec == '0) begin
                            r_volume   <= '0;
                            r_done     <= 1'b1;
                            r_ready_en <= 1'b1;
                            r_state    <= IDLE;
                        end else if (w_mute_wrap) begin
                            r_volume <= '0;
                        end
                    end else begin
                        r_pre <= r_pre + 1'b1;
                    end
                end
                default: begin
                    r_ready_en <= 1'b1;
                    r_state    <= IDLE;
                end
            endcase
        end
    end

    assign bus.note_ready      = w_ready;
    assign bus.new_period      = r_new_period;
    assign bus.clks_per_period = r_period;
    assign bus.volume          = r_volume;
    assign bus.busy            = (r_state != IDLE);
    assign bus.done            = r_done;

endmodule
`default_nettype wire
